// File: rtl/hdmi_timing_ctrl_pkg.sv
// Shared raster types and timing helpers for the HDMI timing controller.
package hdmi_timing_ctrl_pkg;

  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    STOP
  } state_t;

  function automatic logic [CNT_W-1:0] tm_total(input int unsigned active, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
    return CNT_W'(active + fp + sync + bp);
  endfunction

  function automatic logic [CNT_W-1:0] tm_sync_start(input int unsigned active, input int unsigned fp);
    return CNT_W'(active + fp);
  endfunction

  function automatic logic [CNT_W-1:0] tm_sync_end(input int unsigned active, input int unsigned fp,
                                                   input int unsigned sync);
    return CNT_W'(active + fp + sync);
  endfunction

endpackage

// File: rtl/hdmi_raster_cnt.sv
// Horizontal/vertical raster counters with active and sync-window decode.
module hdmi_raster_cnt
  import hdmi_timing_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             h_last,
  output logic             v_last
);

  localparam logic [CNT_W-1:0] H_LAST   = tm_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1'b1;
  localparam logic [CNT_W-1:0] V_LAST   = tm_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1'b1;
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = tm_sync_start(H_ACTIVE, H_FP);
  localparam logic [CNT_W-1:0] HS_END   = tm_sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = tm_sync_start(V_ACTIVE, V_FP);
  localparam logic [CNT_W-1:0] VS_END   = tm_sync_end(V_ACTIVE, V_FP, V_SYNC);

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge pclk) begin
    if (reset || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_act = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync_act = (v_cnt >= VS_START) && (v_cnt < VS_END);

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing controller: raster FSM, FIFO read scheduling, underrun fill
// and a 2-stage registered output pipeline towards the DVI/HDMI transmitter.
module hdmi_timing_ctrl
  import hdmi_timing_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter logic        HS_POL     = 1'b1,
  parameter logic        VS_POL     = 1'b1,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        video_en,
  output logic        frame_req,
  input  logic        pix_ready,
  input  logic        pix_empty,
  output logic        pix_rd_en,
  input  logic [23:0] pix_data,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic [23:0] video_din,
  output logic        busy,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);

  state_t           state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hsync_act;
  logic             vsync_act;
  logic             h_last;
  logic             v_last;
  logic             running;
  logic             de0;
  logic             under0;
  logic             de1;
  logic             hs1;
  logic             vs1;
  logic             under1;

  assign running = (state == RUN) || (state == STOP);
  assign busy    = (state != IDLE);

  hdmi_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .pclk      (pclk),
    .reset     (reset),
    .clear     (!running),
    .en        (running),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .h_last    (h_last),
    .v_last    (v_last)
  );

  // Stage 0: read strobe is issued combinationally so data lands in stage 1.
  assign de0       = running && active;
  assign under0    = de0 && pix_empty;
  assign pix_rd_en = de0 && !pix_empty;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= IDLE;
      frame_req <= 1'b0;
    end else begin
      frame_req <= 1'b0;
      case (state)
        IDLE: begin
          if (video_en) begin
            state     <= PRIME;
            frame_req <= 1'b1;
          end
        end
        PRIME: begin
          if (!video_en)
            state <= IDLE;
          else if (pix_ready)
            state <= RUN;
        end
        RUN: begin
          if ((h_cnt == '0) && (v_cnt == V_ACT)) begin
            if (video_en)
              frame_req <= 1'b1;
            else
              state <= STOP;
          end
        end
        STOP: begin
          if (h_last && v_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      de1           <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      under1        <= 1'b0;
      video_de      <= 1'b0;
      video_hsync   <= !HS_POL;
      video_vsync   <= !VS_POL;
      video_din     <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      de1         <= de0;
      hs1         <= running && hsync_act;
      vs1         <= running && vsync_act;
      under1      <= under0;
      video_de    <= de1;
      video_hsync <= hs1 ? HS_POL : !HS_POL;
      video_vsync <= vs1 ? VS_POL : !VS_POL;
      video_din   <= de1 ? (under1 ? FILL_COLOR : pix_data) : '0;
      if (under1) begin
        underflow <= 1'b1;
        if (underflow_cnt != '1)
          underflow_cnt <= underflow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench for hdmi_timing_ctrl on a tiny 8x5 raster (40 pclk per frame).
module tb_hdmi_timing_ctrl;

  localparam logic [23:0] FILL = 24'hF0F0F0;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        video_en = 1'b0;
  logic        frame_req;
  logic        pix_ready = 1'b0;
  logic        pix_empty;
  logic        pix_rd_en;
  logic [23:0] pix_data = '0;
  logic        video_hsync;
  logic        video_vsync;
  logic        video_de;
  logic [23:0] video_din;
  logic        busy;
  logic        underflow;
  logic [15:0] underflow_cnt;

  logic [23:0] fifo_mem [64];
  int unsigned rd_ptr = 0;
  logic        force_empty = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          k;
  logic [23:0] exp_pix = 24'd1;

  always #5 pclk = ~pclk;

  hdmi_timing_ctrl #(
    .H_ACTIVE   (4),
    .H_FP       (1),
    .H_SYNC     (2),
    .H_BP       (1),
    .V_ACTIVE   (2),
    .V_FP       (1),
    .V_SYNC     (1),
    .V_BP       (1),
    .HS_POL     (1'b1),
    .VS_POL     (1'b1),
    .FILL_COLOR (FILL)
  ) dut (
    .pclk          (pclk),
    .reset         (reset),
    .video_en      (video_en),
    .frame_req     (frame_req),
    .pix_ready     (pix_ready),
    .pix_empty     (pix_empty),
    .pix_rd_en     (pix_rd_en),
    .pix_data      (pix_data),
    .video_hsync   (video_hsync),
    .video_vsync   (video_vsync),
    .video_de      (video_de),
    .video_din     (video_din),
    .busy          (busy),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  // FIFO model: data appears one cycle after the read strobe.
  assign pix_empty = force_empty || (rd_ptr >= 64);
  always @(posedge pclk) begin
    if (pix_rd_en) begin
      pix_data <= fifo_mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  function automatic logic f_act(input int pos);
    return ((pos % 8) < 4) && (((pos / 8) % 5) < 2);
  endfunction
  function automatic logic f_hs(input int pos);
    return ((pos % 8) >= 5) && ((pos % 8) < 7);
  endfunction
  function automatic logic f_vs(input int pos);
    return ((pos / 8) % 5) == 3;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge pclk);
    n_cmp++; if (video_de !== 1'b0) begin n_err++; $display("FAIL reset_de: got %b exp 0", video_de); end
    n_cmp++; if (video_din !== 24'h0) begin n_err++; $display("FAIL reset_din: got %h exp 0", video_din); end
    n_cmp++; if (video_hsync !== 1'b0) begin n_err++; $display("FAIL reset_hsync: got %b exp 0", video_hsync); end
    n_cmp++; if (video_vsync !== 1'b0) begin n_err++; $display("FAIL reset_vsync: got %b exp 0", video_vsync); end
    n_cmp++; if (frame_req !== 1'b0) begin n_err++; $display("FAIL reset_frame_req: got %b exp 0", frame_req); end
    n_cmp++; if (pix_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b exp 0", pix_rd_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if ({underflow, underflow_cnt} !== 17'h0) begin n_err++; $display("FAIL reset_underflow: got %b/%0d exp 0/0", underflow, underflow_cnt); end
    reset = 1'b0;
    @(negedge pclk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_start();
    video_en = 1'b1;
    @(negedge pclk);
    n_cmp++; if (frame_req !== 1'b1) begin n_err++; $display("FAIL start_frame_req: got %b exp 1", frame_req); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b exp 1", busy); end
    @(negedge pclk);
    n_cmp++; if (frame_req !== 1'b0) begin n_err++; $display("FAIL start_frame_req_once: got %b exp 0", frame_req); end
    @(negedge pclk);
    n_cmp++; if (frame_req !== 1'b0 || video_de !== 1'b0) begin n_err++; $display("FAIL prime_quiet: got req %b de %b exp 0 0", frame_req, video_de); end
    n_cmp++; if (pix_rd_en !== 1'b0) begin n_err++; $display("FAIL prime_rd_en: got %b exp 0", pix_rd_en); end
    pix_ready = 1'b1;
    @(negedge pclk);
    k = 0;
  endtask

  task automatic test_data_path();
    int   de_cnt = 0;
    logic e_de, e_hs, e_vs;
    for (int i = 0; i < 40; i++) begin
      #1;
      e_de = (k >= 2) && f_act(k - 2);
      e_hs = (k >= 2) && f_hs(k - 2);
      e_vs = (k >= 2) && f_vs(k - 2);
      n_cmp++; if (video_de !== e_de) begin n_err++; $display("FAIL dp_de k=%0d: got %b exp %b", k, video_de, e_de); end
      n_cmp++; if (video_hsync !== e_hs) begin n_err++; $display("FAIL dp_hsync k=%0d: got %b exp %b", k, video_hsync, e_hs); end
      n_cmp++; if (video_vsync !== e_vs) begin n_err++; $display("FAIL dp_vsync k=%0d: got %b exp %b", k, video_vsync, e_vs); end
      n_cmp++; if (video_din !== (e_de ? exp_pix : 24'h0)) begin n_err++; $display("FAIL dp_din k=%0d: got %h exp %h", k, video_din, e_de ? exp_pix : 24'h0); end
      n_cmp++; if (pix_rd_en !== f_act(k)) begin n_err++; $display("FAIL dp_rd_en k=%0d: got %b exp %b", k, pix_rd_en, f_act(k)); end
      n_cmp++; if (frame_req !== (k % 40 == 17)) begin n_err++; $display("FAIL dp_frame_req k=%0d: got %b", k, frame_req); end
      if (e_de) begin de_cnt++; exp_pix++; end
      k++;
      @(negedge pclk);
    end
    n_cmp++; if (de_cnt != 8) begin n_err++; $display("FAIL dp_de_count: got %0d exp 8", de_cnt); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL dp_underflow: got %b exp 0", underflow); end
  endtask

  task automatic test_underrun();
    logic        e_de;
    logic [23:0] e_din;
    for (int i = 0; i < 40; i++) begin
      force_empty = (k == 42);
      #1;
      e_de  = f_act(k - 2);
      e_din = !e_de ? 24'h0 : (k == 44) ? FILL : exp_pix;
      n_cmp++; if (video_de !== e_de) begin n_err++; $display("FAIL ur_de k=%0d: got %b exp %b", k, video_de, e_de); end
      n_cmp++; if (video_din !== e_din) begin n_err++; $display("FAIL ur_din k=%0d: got %h exp %h", k, video_din, e_din); end
      n_cmp++; if (video_hsync !== f_hs(k - 2)) begin n_err++; $display("FAIL ur_hsync k=%0d: got %b", k, video_hsync); end
      n_cmp++; if (pix_rd_en !== (f_act(k) && !force_empty)) begin n_err++; $display("FAIL ur_rd_en k=%0d: got %b", k, pix_rd_en); end
      n_cmp++; if (frame_req !== (k % 40 == 17)) begin n_err++; $display("FAIL ur_frame_req k=%0d: got %b", k, frame_req); end
      if (e_de && k != 44) exp_pix++;
      k++;
      @(negedge pclk);
    end
    force_empty = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL ur_flag: got %b exp 1", underflow); end
    n_cmp++; if (underflow_cnt !== 16'd1) begin n_err++; $display("FAIL ur_count: got %0d exp 1", underflow_cnt); end
  endtask

  task automatic test_steady_run();
    int   req_cnt = 0;
    logic e_de;
    for (int i = 0; i < 40; i++) begin
      #1;
      e_de = f_act(k - 2);
      n_cmp++; if (video_de !== e_de) begin n_err++; $display("FAIL sr_de k=%0d: got %b exp %b", k, video_de, e_de); end
      n_cmp++; if (video_din !== (e_de ? exp_pix : 24'h0)) begin n_err++; $display("FAIL sr_din k=%0d: got %h exp %h", k, video_din, e_de ? exp_pix : 24'h0); end
      n_cmp++; if (video_vsync !== f_vs(k - 2)) begin n_err++; $display("FAIL sr_vsync k=%0d: got %b", k, video_vsync); end
      n_cmp++; if (frame_req !== (k % 40 == 17)) begin n_err++; $display("FAIL sr_frame_req k=%0d: got %b", k, frame_req); end
      if (frame_req === 1'b1) req_cnt++;
      if (e_de) exp_pix++;
      k++;
      @(negedge pclk);
    end
    n_cmp++; if (req_cnt != 1) begin n_err++; $display("FAIL sr_req_count: got %0d exp 1", req_cnt); end
    n_cmp++; if (underflow_cnt !== 16'd1) begin n_err++; $display("FAIL sr_count_hold: got %0d exp 1", underflow_cnt); end
  endtask

  task automatic test_stop();
    logic e_de, e_hs, e_vs;
    for (int i = 0; i < 50; i++) begin
      if (k == 121) video_en = 1'b0;
      #1;
      e_de = (k - 2 < 160) && f_act(k - 2);
      e_hs = (k - 2 < 160) && f_hs(k - 2);
      e_vs = (k - 2 < 160) && f_vs(k - 2);
      n_cmp++; if (video_de !== e_de) begin n_err++; $display("FAIL st_de k=%0d: got %b exp %b", k, video_de, e_de); end
      n_cmp++; if (video_din !== (e_de ? exp_pix : 24'h0)) begin n_err++; $display("FAIL st_din k=%0d: got %h exp %h", k, video_din, e_de ? exp_pix : 24'h0); end
      n_cmp++; if (video_hsync !== e_hs || video_vsync !== e_vs) begin n_err++; $display("FAIL st_sync k=%0d: got %b%b exp %b%b", k, video_hsync, video_vsync, e_hs, e_vs); end
      n_cmp++; if (pix_rd_en !== ((k < 160) && f_act(k))) begin n_err++; $display("FAIL st_rd_en k=%0d: got %b", k, pix_rd_en); end
      n_cmp++; if (frame_req !== 1'b0) begin n_err++; $display("FAIL st_frame_req k=%0d: got %b exp 0", k, frame_req); end
      n_cmp++; if (busy !== (k < 160)) begin n_err++; $display("FAIL st_busy k=%0d: got %b exp %b", k, busy, k < 160); end
      if (e_de) exp_pix++;
      k++;
      @(negedge pclk);
    end
  endtask

  task automatic test_reset_mid();
    video_en = 1'b1;
    @(negedge pclk);
    n_cmp++; if (frame_req !== 1'b1) begin n_err++; $display("FAIL rm_frame_req: got %b exp 1", frame_req); end
    @(negedge pclk);
    repeat (10) @(negedge pclk);
    n_cmp++; if (video_de !== 1'b1 || pix_rd_en !== 1'b1) begin n_err++; $display("FAIL rm_pre: got de %b rd %b exp 1 1", video_de, pix_rd_en); end
    reset    = 1'b1;
    video_en = 1'b0;
    @(negedge pclk);
    n_cmp++; if (video_de !== 1'b0) begin n_err++; $display("FAIL rm_de: got %b exp 0", video_de); end
    n_cmp++; if (video_din !== 24'h0) begin n_err++; $display("FAIL rm_din: got %h exp 0", video_din); end
    n_cmp++; if (video_hsync !== 1'b0 || video_vsync !== 1'b0) begin n_err++; $display("FAIL rm_sync: got %b%b exp 00", video_hsync, video_vsync); end
    n_cmp++; if (pix_rd_en !== 1'b0) begin n_err++; $display("FAIL rm_rd_en: got %b exp 0", pix_rd_en); end
    n_cmp++; if (underflow_cnt !== 16'd0 || underflow !== 1'b0) begin n_err++; $display("FAIL rm_underflow: got %b/%0d exp 0/0", underflow, underflow_cnt); end
    reset = 1'b0;
    repeat (3) @(negedge pclk);
    n_cmp++; if (video_de !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rm_flushed: got de %b busy %b exp 0 0", video_de, busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) fifo_mem[i] = 24'(i + 1);
    @(negedge pclk);
    test_reset();
    test_start();
    test_data_path();
    test_underrun();
    test_steady_run();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hdmi_timing_ctrl.md
# hdmi_timing_ctrl

Video timing controller and pixel scheduler that sequences the DVI/HDMI transmitter. It generates the raster: horizontal/vertical counters, hsync, vsync and de. It pulls RGB888 pixels from the upstream frame-buffer read FIFO through a read-enable handshake and asks the DDR read engine for each frame at the right time. It also sequences start/stop on frame boundaries and substitutes a fill colour (with error counting) when the FIFO underruns. It sits between the DDR read FIFO and the transmitter's video_din/video_hsync/video_vsync/video_de inputs, in the pclk domain.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pclk)
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- HS_POL, 1'b1, hsync active level
- VS_POL, 1'b1, vsync active level
- FILL_COLOR, 24'h000000, pixel substituted on underrun

Ports:
- pclk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- video_en  in  1  level; request to run video
- frame_req  out  1  one-cycle pulse asking the DDR read engine to start streaming a frame
- pix_ready  in  1  FIFO primed (holds at least one line)
- pix_empty  in  1  FIFO empty
- pix_rd_en  out  1  FIFO read strobe
- pix_data  in  24  FIFO data, valid exactly 1 cycle after pix_rd_en
- video_hsync  out  1  to transmitter
- video_vsync  out  1  to transmitter
- video_de  out  1  to transmitter
- video_din  out  24  RGB888 {R,G,B} to transmitter
- busy  out  1  state != IDLE
- underflow  out  1  sticky underrun flag
- underflow_cnt  out  16  underrun pixel count, saturating

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; both must be ≤ 4095. Counters h_cnt and v_cnt are 12 bits.
- Raster order per line: active [0, H_ACTIVE), then FP, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then BP. The vertical raster uses the same order, counted in lines.
- h_cnt wraps at H_TOTAL-1 → 0. v_cnt increments on each h wrap and wraps at V_TOTAL-1 → 0.
- FSM states and transitions:
  - IDLE: counters held at 0. When video_en=1, pulse frame_req and go to PRIME.
  - PRIME: wait for pix_ready=1, then go to RUN with h_cnt=v_cnt=0. video_en dropping here returns the FSM to IDLE.
  - RUN: counters advance every cycle.
    - At h_cnt=0, v_cnt=V_ACTIVE (start of vertical blanking) with video_en=1: pulse frame_req for the next frame.
    - At the same point with video_en=0: go to STOP, with no frame_req.
  - STOP: counters keep running. At h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, go to IDLE. Frames are never truncated.
- Read scheduling: in the active area, pix_rd_en = !pix_empty. If pix_empty=1 there, pix_rd_en stays 0 and that pixel is an underrun.
- Underrun handling:
  - The output pixel becomes FILL_COLOR and underflow is set.
  - underflow_cnt increments and saturates at 16'hFFFF.
  - Both clear only on reset.
  - The raster never stalls.
- Outside the active area and outside RUN/STOP, pix_rd_en=0.

## Timing
- Pipeline stage 0: counters, raster decode and pix_rd_en. Stage 1: pix_data valid; hit/underrun flag delayed 1 cycle. Stage 2: all video_* outputs registered.
- Latency: exactly 2 pclk from counter value to output. The sync, de and pixel for a given (h,v) appear together.
- frame_req is registered, high for exactly 1 cycle.
- Reset values:
  - video_hsync = !HS_POL, video_vsync = !VS_POL
  - video_de = 0, video_din = 0, pix_rd_en = 0, frame_req = 0
  - busy = 0, underflow = 0, underflow_cnt = 0
  - state = IDLE
- Reset mid-frame: all outputs take their reset values on the next edge. The 2-cycle pipeline is flushed, with no stale de.
- In IDLE and PRIME the outputs are held at their inactive levels: sync inactive, de=0, din=0.
- When leaving STOP to IDLE, the last 2 pipeline cycles drain normally, so they are blanking values.

## Structure
- Shared package: the timing constants (H_TOTAL, V_TOTAL and the sync start/end points, computed from the parameters) and the FSM state enum (IDLE, PRIME, RUN, STOP).
- One sub-module is natural: hdmi_raster_cnt. It holds the h/v counters plus active/hsync/vsync decode, with enable and clear inputs. The FSM, read scheduler and output pipeline stay in the top.

## Test plan
Bench timing for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=5); 40 pclk per frame.
- Start: video_en=1 then pix_ready=1 three cycles later → frame_req pulses once in the cycle after video_en. Then 8 de-high cycles per frame, in 2 runs of 4, with the first de 2 cycles after entering RUN. hsync is 2 cycles wide on every line; vsync is 8 cycles wide in line 3.
- Data path: FIFO preloaded with 24'h000001…24'h000008 → video_din equals those values, in order, exactly while de=1. underflow stays 0.
- Underrun: pix_empty forced to 1 for the 3rd active pixel of frame 1 → that pixel = FILL_COLOR. underflow=1, underflow_cnt=1, and the raster period stays 40 cycles.
- Steady run: video_en held at 1 → frame_req pulses at h=0, v=2 of each frame (every 40 cycles).
- Stop: video_en=0 during line 0 → the frame completes. No further frame_req, then IDLE. busy=0 after the final edge at h=7, v=4.
- Reset mid-active: reset asserted at h=2, v=1 → the next cycle shows de=0, din=0, syncs inactive and pix_rd_en=0; underflow_cnt=0.
